// File: rtl/pcie_rx_tlp_engine.sv
// PCIe RX TLP engine: splits a 128-bit AXI4-Stream RX channel into single-DW
// memory read requests, DW-serialised memory writes and completion data beats.
// Unsupported or malformed TLPs are discarded and counted.
module pcie_rx_tlp_engine #(
  parameter int unsigned P_MAX_WR_DW = 32,
  parameter logic [7:0]  P_BAR_MASK  = 8'h01,
  parameter int unsigned P_CNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [127:0]           s_axis_rx_tdata,
  input  logic                   s_axis_rx_tvalid,
  input  logic                   s_axis_rx_tlast,
  input  logic [21:0]            s_axis_rx_tuser,
  output logic                   s_axis_rx_tready,
  output logic                   rd_req_valid,
  output logic [63:0]            rd_req_addr,
  output logic [3:0]             rd_req_be,
  output logic [2:0]             rd_req_tc,
  output logic [1:0]             rd_req_attr,
  output logic [15:0]            rd_req_rid,
  output logic [7:0]             rd_req_tag,
  output logic [2:0]             rd_req_bar,
  input  logic                   rd_req_ready,
  output logic                   wr_valid,
  output logic [63:0]            wr_addr,
  output logic [31:0]            wr_data,
  output logic [3:0]             wr_be,
  output logic                   wr_last,
  output logic [2:0]             wr_bar,
  input  logic                   wr_ready,
  output logic [127:0]           cpl_dout,
  output logic [1:0]             cpl_first_dw,
  output logic                   cpl_valid,
  output logic                   cpl_done,
  output logic [7:0]             cpl_tag,
  output logic [P_CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_EMIT, WR_FETCH, CPL, DROP} state_t;

  state_t       state;
  logic [127:0] wbuf;
  logic [1:0]   widx;
  logic [10:0]  wleft;
  logic         wfirst;
  logic [3:0]   wfbe;
  logic [3:0]   wlbe;
  logic         tlast_seen;
  logic [10:0]  cpl_rem;

  logic [31:0]  h0, h1, h2, h3;
  logic [6:0]   fmt_type;
  logic [10:0]  len_dw;
  logic [63:0]  tlp_addr;
  logic [7:0]   bar_sel;
  logic         bar_ok;
  logic [2:0]   bar_idx;
  logic         sof;
  logic         beat_acc;
  logic         acc_mrd, acc_mwr, acc_cpl;
  logic         unused_bits;

  assign h0       = s_axis_rx_tdata[31:0];
  assign h1       = s_axis_rx_tdata[63:32];
  assign h2       = s_axis_rx_tdata[95:64];
  assign h3       = s_axis_rx_tdata[127:96];
  assign fmt_type = h0[30:24];
  assign sof      = s_axis_rx_tuser[14];
  assign bar_sel  = s_axis_rx_tuser[9:2] & P_BAR_MASK;
  assign bar_ok   = |bar_sel;
  assign beat_acc = s_axis_rx_tvalid && s_axis_rx_tready;

  assign unused_bits = ^{h0[31], h0[23], h0[19:14], h0[11:10],
                         s_axis_rx_tuser[21:15], s_axis_rx_tuser[13:10],
                         s_axis_rx_tuser[1:0]};

  // Ready depends only on the state: stalled while an output handshake is pending
  always_comb begin
    s_axis_rx_tready = (state == IDLE) || (state == WR_FETCH) ||
                       (state == CPL)  || (state == DROP);
  end

  // Header decode of the current beat: length, address, BAR and acceptance
  always_comb begin
    len_dw   = (h0[9:0] == 10'd0) ? 11'd1024 : {1'b0, h0[9:0]};
    tlp_addr = fmt_type[5] ? {h2, h3[31:2], 2'b00} : {32'h0, h2[31:2], 2'b00};
    bar_idx  = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (bar_sel[i-1]) bar_idx = 3'(i - 1);
    end
    acc_mrd = ((fmt_type == 7'h00) || (fmt_type == 7'h20)) && (h0[9:0] == 10'd1) && bar_ok;
    acc_mwr = ((fmt_type == 7'h40) || (fmt_type == 7'h60)) &&
              (len_dw <= 11'(P_MAX_WR_DW)) && bar_ok;
    acc_cpl = (fmt_type == 7'h4A) && bar_ok;
  end

  // First DW of a write uses first BE, a later final DW uses last BE
  function automatic logic [3:0] dw_be(input logic first, input logic [10:0] left,
                                       input logic [3:0] fbe, input logic [3:0] lbe);
    if (first)            return fbe;
    else if (left == 11'd1) return lbe;
    else                  return 4'hF;
  endfunction

  // Main FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_be    <= '0;
      rd_req_tc    <= '0;
      rd_req_attr  <= '0;
      rd_req_rid   <= '0;
      rd_req_tag   <= '0;
      rd_req_bar   <= '0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_be        <= '0;
      wr_last      <= 1'b0;
      wr_bar       <= '0;
      cpl_dout     <= '0;
      cpl_first_dw <= '0;
      cpl_valid    <= 1'b0;
      cpl_done     <= 1'b0;
      cpl_tag      <= '0;
      drop_cnt     <= '0;
      wbuf         <= '0;
      widx         <= '0;
      wleft        <= '0;
      wfirst       <= 1'b0;
      wfbe         <= '0;
      wlbe         <= '0;
      tlast_seen   <= 1'b0;
      cpl_rem      <= '0;
    end else begin
      cpl_valid <= 1'b0;
      cpl_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (beat_acc && sof) begin
            if (acc_mrd) begin
              rd_req_valid <= 1'b1;
              rd_req_addr  <= tlp_addr;
              rd_req_be    <= h1[3:0];
              rd_req_tc    <= h0[22:20];
              rd_req_attr  <= h0[13:12];
              rd_req_rid   <= h1[31:16];
              rd_req_tag   <= h1[15:8];
              rd_req_bar   <= bar_idx;
              state        <= RD_REQ;
            end else if (acc_mwr) begin
              wr_addr    <= tlp_addr;
              wr_bar     <= bar_idx;
              wfbe       <= h1[3:0];
              wlbe       <= h1[7:4];
              wleft      <= len_dw;
              wfirst     <= 1'b1;
              tlast_seen <= s_axis_rx_tlast;
              if (fmt_type[5]) begin
                state <= WR_FETCH;
              end else begin
                wbuf     <= s_axis_rx_tdata;
                widx     <= 2'd3;
                wr_valid <= 1'b1;
                wr_data  <= h3;
                wr_be    <= h1[3:0];
                wr_last  <= (len_dw == 11'd1);
                state    <= WR_EMIT;
              end
            end else if (acc_cpl) begin
              cpl_dout     <= s_axis_rx_tdata;
              cpl_first_dw <= 2'd3;
              cpl_tag      <= h2[15:8];
              cpl_valid    <= 1'b1;
              cpl_rem      <= len_dw - 11'd1;
              if (len_dw == 11'd1) cpl_done <= 1'b1;
              else                 state    <= CPL;
            end else begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
              if (!s_axis_rx_tlast) state <= DROP;
            end
          end
        end
        RD_REQ: begin
          if (rd_req_ready) begin
            rd_req_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        WR_EMIT: begin
          if (wr_ready) begin
            wr_addr <= wr_addr + 64'd4;
            wleft   <= wleft - 11'd1;
            wfirst  <= 1'b0;
            if (wleft == 11'd1) begin
              wr_valid <= 1'b0;
              wr_last  <= 1'b0;
              state    <= tlast_seen ? IDLE : DROP;
            end else if (widx == 2'd3) begin
              wr_valid <= 1'b0;
              state    <= WR_FETCH;
            end else begin
              widx    <= widx + 2'd1;
              wr_data <= wbuf[{widx + 2'd1, 5'd0} +: 32];
              wr_be   <= dw_be(1'b0, wleft - 11'd1, wfbe, wlbe);
              wr_last <= (wleft == 11'd2);
            end
          end
        end
        WR_FETCH: begin
          // Shared by the 4DW first payload beat and every continuation beat
          if (beat_acc) begin
            wbuf       <= s_axis_rx_tdata;
            widx       <= 2'd0;
            tlast_seen <= s_axis_rx_tlast;
            wr_valid   <= 1'b1;
            wr_data    <= s_axis_rx_tdata[31:0];
            wr_be      <= dw_be(wfirst, wleft, wfbe, wlbe);
            wr_last    <= (wleft == 11'd1);
            state      <= WR_EMIT;
          end
        end
        CPL: begin
          if (beat_acc) begin
            cpl_dout     <= s_axis_rx_tdata;
            cpl_valid    <= 1'b1;
            cpl_first_dw <= (cpl_rem < 11'd4) ? (2'd0 - cpl_rem[1:0]) : 2'd0;
            cpl_rem      <= cpl_rem - 11'd4;
            if (cpl_rem <= 11'd4) begin
              cpl_done <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        DROP: begin
          if (beat_acc && s_axis_rx_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_rx_tlp_engine.sv
// Directed bench for pcie_rx_tlp_engine: MRd, MWr, CplD, drops and mid-TLP reset.
module tb_pcie_rx_tlp_engine;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [127:0] s_axis_rx_tdata;
  logic         s_axis_rx_tvalid;
  logic         s_axis_rx_tlast;
  logic [21:0]  s_axis_rx_tuser;
  logic         s_axis_rx_tready;
  logic         rd_req_valid;
  logic [63:0]  rd_req_addr;
  logic [3:0]   rd_req_be;
  logic [2:0]   rd_req_tc;
  logic [1:0]   rd_req_attr;
  logic [15:0]  rd_req_rid;
  logic [7:0]   rd_req_tag;
  logic [2:0]   rd_req_bar;
  logic         rd_req_ready;
  logic         wr_valid;
  logic [63:0]  wr_addr;
  logic [31:0]  wr_data;
  logic [3:0]   wr_be;
  logic         wr_last;
  logic [2:0]   wr_bar;
  logic         wr_ready;
  logic [127:0] cpl_dout;
  logic [1:0]   cpl_first_dw;
  logic         cpl_valid;
  logic         cpl_done;
  logic [7:0]   cpl_tag;
  logic [15:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  pcie_rx_tlp_engine #(
    .P_MAX_WR_DW (32),
    .P_BAR_MASK  (8'h01),
    .P_CNT_WIDTH (16)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .s_axis_rx_tdata  (s_axis_rx_tdata),
    .s_axis_rx_tvalid (s_axis_rx_tvalid),
    .s_axis_rx_tlast  (s_axis_rx_tlast),
    .s_axis_rx_tuser  (s_axis_rx_tuser),
    .s_axis_rx_tready (s_axis_rx_tready),
    .rd_req_valid     (rd_req_valid),
    .rd_req_addr      (rd_req_addr),
    .rd_req_be        (rd_req_be),
    .rd_req_tc        (rd_req_tc),
    .rd_req_attr      (rd_req_attr),
    .rd_req_rid       (rd_req_rid),
    .rd_req_tag       (rd_req_tag),
    .rd_req_bar       (rd_req_bar),
    .rd_req_ready     (rd_req_ready),
    .wr_valid         (wr_valid),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_be            (wr_be),
    .wr_last          (wr_last),
    .wr_bar           (wr_bar),
    .wr_ready         (wr_ready),
    .cpl_dout         (cpl_dout),
    .cpl_first_dw     (cpl_first_dw),
    .cpl_valid        (cpl_valid),
    .cpl_done         (cpl_done),
    .cpl_tag          (cpl_tag),
    .drop_cnt         (drop_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  // Present one beat for one cycle; it must be accepted
  task automatic beat(input logic [127:0] d, input logic last, input logic sof,
                      input logic [7:0] bar);
    s_axis_rx_tdata   = d;
    s_axis_rx_tlast   = last;
    s_axis_rx_tuser   = '0;
    s_axis_rx_tuser[14]  = sof;
    s_axis_rx_tuser[9:2] = bar;
    s_axis_rx_tvalid  = 1'b1;
    check("tready_on_beat", s_axis_rx_tready, 1'b1);
    step;
    s_axis_rx_tvalid  = 1'b0;
    s_axis_rx_tlast   = 1'b0;
    s_axis_rx_tuser   = '0;
  endtask

  // Expected view of DW k of the 6-DW MWr64
  task automatic chk_dw(input int k);
    logic [3:0] be;
    be = (k == 0) ? 4'h3 : (k == 5) ? 4'hC : 4'hF;
    check("mwr_valid", wr_valid, 1'b1);
    check("mwr_data",  wr_data, 32'hA0 + 32'(k));
    check("mwr_addr",  wr_addr, 64'h1_0000_0000 + 64'(4 * k));
    check("mwr_be",    wr_be, be);
    check("mwr_last",  wr_last, (k == 5));
    check("mwr_bar",   wr_bar, 3'd0);
    check("mwr_tready_low", s_axis_rx_tready, 1'b0);
  endtask

  initial begin
    i_rst_n          = 1'b0;
    s_axis_rx_tdata  = '0;
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tlast  = 1'b0;
    s_axis_rx_tuser  = '0;
    rd_req_ready     = 1'b0;
    wr_ready         = 1'b0;
    repeat (3) step;

    // Reset state
    check("rst_tready",   s_axis_rx_tready, 1'b1);
    check("rst_rd_valid", rd_req_valid, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_cpl_valid", cpl_valid, 1'b0);
    check("rst_drop_cnt", drop_cnt, 16'd0);
    i_rst_n = 1'b1;
    step;

    // MRd32, length 1, tc 3, attr 2, ready low for 3 cycles
    beat({32'h0, 32'h1000_0004, 32'h0100_120F, 32'h0030_2001}, 1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) begin
      check("mrd_valid_wait",  rd_req_valid, 1'b1);
      check("mrd_addr",        rd_req_addr, 64'h1000_0004);
      check("mrd_tready_low",  s_axis_rx_tready, 1'b0);
      step;
    end
    check("mrd_tag",  rd_req_tag, 8'h12);
    check("mrd_be",   rd_req_be, 4'hF);
    check("mrd_rid",  rd_req_rid, 16'h0100);
    check("mrd_tc",   rd_req_tc, 3'd3);
    check("mrd_attr", rd_req_attr, 2'd2);
    check("mrd_bar",  rd_req_bar, 3'd0);
    rd_req_ready = 1'b1;
    check("mrd_valid_hs", rd_req_valid, 1'b1);
    check("mrd_tready_hs", s_axis_rx_tready, 1'b0);
    step;
    rd_req_ready = 1'b0;
    check("mrd_valid_after", rd_req_valid, 1'b0);
    check("mrd_tready_after", s_axis_rx_tready, 1'b1);

    // MWr64, length 6, addr 0x1_0000_0000, first BE 3, last BE C
    beat({32'h0000_0000, 32'h0000_0001, 32'h0000_00C3, 32'h6000_0006}, 1'b0, 1'b1, 8'h01);
    check("mwr64_fetch_valid", wr_valid, 1'b0);
    beat({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, 1'b0, 8'h01);
    for (int k = 0; k < 4; k++) begin
      chk_dw(k);
      if (k == 1) begin
        step;
        chk_dw(k);
      end
      wr_ready = 1'b1;
      step;
      wr_ready = 1'b0;
    end
    check("mwr_refetch_valid",  wr_valid, 1'b0);
    check("mwr_refetch_tready", s_axis_rx_tready, 1'b1);
    beat({64'h0, 32'hA5, 32'hA4}, 1'b1, 1'b0, 8'h01);
    for (int k = 4; k < 6; k++) begin
      chk_dw(k);
      wr_ready = 1'b1;
      step;
      wr_ready = 1'b0;
    end
    check("mwr_done_valid",  wr_valid, 1'b0);
    check("mwr_done_tready", s_axis_rx_tready, 1'b1);

    // CplD length 7: 1 DW in beat0, then 4, then 2
    beat({32'hC0, 32'h0000_5A00, 32'h0, 32'h4A00_0007}, 1'b0, 1'b1, 8'h01);
    check("cpl7_b0_valid", cpl_valid, 1'b1);
    check("cpl7_b0_fdw",   cpl_first_dw, 2'd3);
    check("cpl7_b0_tag",   cpl_tag, 8'h5A);
    check("cpl7_b0_done",  cpl_done, 1'b0);
    check("cpl7_b0_dout",  cpl_dout, {32'hC0, 32'h0000_5A00, 32'h0, 32'h4A00_0007});
    beat({32'hC4, 32'hC3, 32'hC2, 32'hC1}, 1'b0, 1'b0, 8'h01);
    check("cpl7_b1_valid", cpl_valid, 1'b1);
    check("cpl7_b1_fdw",   cpl_first_dw, 2'd0);
    check("cpl7_b1_done",  cpl_done, 1'b0);
    check("cpl7_b1_dout",  cpl_dout, {32'hC4, 32'hC3, 32'hC2, 32'hC1});
    beat({64'h0, 32'hC6, 32'hC5}, 1'b1, 1'b0, 8'h01);
    check("cpl7_b2_valid", cpl_valid, 1'b1);
    check("cpl7_b2_fdw",   cpl_first_dw, 2'd2);
    check("cpl7_b2_done",  cpl_done, 1'b1);
    step;
    check("cpl7_idle_valid", cpl_valid, 1'b0);
    check("cpl7_idle_done",  cpl_done, 1'b0);

    // CplD length 3 over 2 beats: first_dw 3 then 2, done on the second
    beat({32'hD0, 32'h0000_7700, 32'h0, 32'h4A00_0003}, 1'b0, 1'b1, 8'h01);
    check("cpl3_b0_fdw",  cpl_first_dw, 2'd3);
    check("cpl3_b0_tag",  cpl_tag, 8'h77);
    check("cpl3_b0_done", cpl_done, 1'b0);
    beat({64'h0, 32'hD2, 32'hD1}, 1'b1, 1'b0, 8'h01);
    check("cpl3_b1_valid", cpl_valid, 1'b1);
    check("cpl3_b1_fdw",   cpl_first_dw, 2'd2);
    check("cpl3_b1_done",  cpl_done, 1'b1);

    // CplD length 1: done with beat0
    beat({32'hE0, 32'h0000_3300, 32'h0, 32'h4A00_0001}, 1'b1, 1'b1, 8'h01);
    check("cpl1_valid", cpl_valid, 1'b1);
    check("cpl1_fdw",   cpl_first_dw, 2'd3);
    check("cpl1_done",  cpl_done, 1'b1);
    check("cpl1_tag",   cpl_tag, 8'h33);

    // Drops: oversize MWr32 (two beats), MRd length 2, MRd BAR miss
    beat({32'hF0, 32'h0000_4000, 32'h0000_00FF, 32'h4000_0021}, 1'b0, 1'b1, 8'h01);
    check("drop_mwr_cnt",   drop_cnt, 16'd1);
    check("drop_mwr_valid", wr_valid, 1'b0);
    beat({32'h4000_0001, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b1, 8'h01);
    check("drop_tail_cnt",   drop_cnt, 16'd1);
    check("drop_tail_valid", wr_valid, 1'b0);
    beat({32'h0, 32'h1000_0000, 32'h0100_120F, 32'h0000_0002}, 1'b1, 1'b1, 8'h01);
    check("drop_len2_cnt",   drop_cnt, 16'd2);
    check("drop_len2_valid", rd_req_valid, 1'b0);
    beat({32'h0, 32'h1000_0000, 32'h0100_120F, 32'h0000_0001}, 1'b1, 1'b1, 8'h02);
    check("drop_bar_cnt",   drop_cnt, 16'd3);
    check("drop_bar_valid", rd_req_valid, 1'b0);
    check("drop_bar_addr",  rd_req_addr, 64'h1000_0004);
    beat({32'h0, 32'h1000_0000, 32'h0100_120F, 32'h0000_0001}, 1'b1, 1'b0, 8'h01);
    check("nosof_cnt",   drop_cnt, 16'd3);
    check("nosof_valid", rd_req_valid, 1'b0);

    // Reset in the middle of a 4-beat MWr32 (length 10)
    beat({32'hD0, 32'h0000_2000, 32'h0000_00FF, 32'h4000_000A}, 1'b0, 1'b1, 8'h01);
    check("mid_wr_valid", wr_valid, 1'b1);
    check("mid_wr_addr",  wr_addr, 64'h2000);
    check("mid_wr_data",  wr_data, 32'hD0);
    i_rst_n = 1'b0;
    step;
    i_rst_n = 1'b1;
    check("rst2_wr_valid", wr_valid, 1'b0);
    check("rst2_wr_addr",  wr_addr, 64'h0);
    check("rst2_wr_data",  wr_data, 32'h0);
    check("rst2_wr_be",    wr_be, 4'h0);
    check("rst2_rd_addr",  rd_req_addr, 64'h0);
    check("rst2_cpl_dout", cpl_dout, 128'h0);
    check("rst2_cpl_tag",  cpl_tag, 8'h0);
    check("rst2_drop_cnt", drop_cnt, 16'd0);
    check("rst2_tready",   s_axis_rx_tready, 1'b1);
    beat({32'hD4, 32'hD3, 32'hD2, 32'hD1}, 1'b0, 1'b0, 8'h01);
    beat({32'hD8, 32'hD7, 32'hD6, 32'hD5}, 1'b0, 1'b0, 8'h01);
    beat({96'h0, 32'hD9}, 1'b1, 1'b0, 8'h01);
    check("post_rst_wr_valid", wr_valid, 1'b0);
    check("post_rst_drop_cnt", drop_cnt, 16'd0);
    check("post_rst_tready",   s_axis_rx_tready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
